// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: frames 6-byte commands, checks CRC7, tracks idle/ready
// and answers R1/R3/R7 on MISO. SPI pins are oversampled on CLK.
module sd_spi_responder #(
  parameter int          NCR         = 1,
  parameter int          ACMD41_BUSY = 2,
  parameter int          INIT_CLKS   = 74,
  parameter logic [31:0] OCR         = 32'hC0FF8000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        CS,
  output logic        MISO,
  output logic        CMD_STB,
  output logic [5:0]  CMD_IDX,
  output logic [31:0] CMD_ARG,
  output logic        CRC_OK,
  output logic        IDLE
);

  localparam int IW = $clog2(INIT_CLKS + 1);
  localparam int BW = $clog2(ACMD41_BUSY + 2);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_NCR   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]    r_sclk_q;
  logic [1:0]    r_mosi_q;
  logic [1:0]    r_cs_q;
  logic [2:0]    r_state;
  logic [2:0]    r_bitcnt;
  logic [6:0]    r_rxsh;
  logic          r_wrap;
  logic [7:0]    r_tx;
  logic [IW-1:0] r_initcnt;
  logic [39:0]   r_frame;
  logic [2:0]    r_bytecnt;
  logic [39:0]   r_resp;
  logic [2:0]    r_len;
  logic [3:0]    r_txcnt;
  logic          r_idle;
  logic          r_app;
  logic [BW-1:0] r_busy;
  logic          r_stb;
  logic [5:0]    r_idx;
  logic [31:0]   r_arg;
  logic          r_crc_ok;

  logic          w_rise, w_fall, w_mosi, w_cs, w_byte_done, w_crc_ok, w_crc_err;
  logic [7:0]    w_byte, w_tx_next;
  logic [5:0]    w_idx;
  logic [31:0]   w_arg;
  logic          w_n_idle, w_n_app;
  logic [BW-1:0] w_n_busy;
  logic [39:0]   w_resp;
  logic [2:0]    w_len;

  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign w_rise      = r_sclk_q[1] & ~r_sclk_q[2];
  assign w_fall      = ~r_sclk_q[1] & r_sclk_q[2];
  assign w_mosi      = r_mosi_q[1];
  assign w_cs        = r_cs_q[1];
  assign w_byte_done = w_rise & ~w_cs & (r_bitcnt == 3'd7);
  assign w_byte      = {r_rxsh, w_mosi};
  assign w_idx       = r_frame[37:32];
  assign w_arg       = r_frame[31:0];
  assign w_crc_ok    = (f_crc7(r_frame) == w_byte[7:1]);
  assign w_crc_err   = ~w_crc_ok & ((w_idx == 6'd0) | (w_idx == 6'd8));
  assign w_tx_next   = (r_state == S_RESP && r_txcnt != {1'b0, r_len}) ? r_resp[39:32] : 8'hFF;

  // Response and next card state for the frame completing this cycle
  always_comb begin
    w_n_idle = r_idle;
    w_n_app  = 1'b0;
    w_n_busy = r_busy;
    w_resp   = {7'b0, r_idle, 32'hFFFF_FFFF};
    w_len    = 3'd1;
    if (w_crc_err) begin
      w_n_app       = r_app;
      w_resp[39:32] = {4'b0, 1'b1, 2'b0, r_idle};
    end else begin
      case (w_idx)
        6'd0: begin
          w_n_idle      = 1'b1;
          w_n_busy      = BW'(ACMD41_BUSY);
          w_resp[39:32] = 8'h01;
        end
        6'd8: begin
          w_resp = {7'b0, r_idle, 16'h0000, 4'h0, w_arg[11:0]};
          w_len  = 3'd5;
        end
        6'd55: w_n_app = 1'b1;
        6'd41: begin
          if (!r_app) begin
            w_resp[39:32] = {5'b0, 1'b1, 1'b0, r_idle};
          end else if (r_busy != '0) begin
            w_n_busy      = r_busy - 1'b1;
            w_resp[39:32] = 8'h01;
          end else begin
            w_n_idle      = 1'b0;
            w_resp[39:32] = 8'h00;
          end
        end
        6'd58: begin
          w_resp = {7'b0, r_idle, OCR};
          w_len  = 3'd5;
        end
        default: w_resp[39:32] = {5'b0, 1'b1, 1'b0, r_idle};
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sclk_q  <= '0;
      r_mosi_q  <= '1;
      r_cs_q    <= '1;
      r_state   <= S_PWRUP;
      r_bitcnt  <= '0;
      r_rxsh    <= '0;
      r_wrap    <= 1'b0;
      r_tx      <= 8'hFF;
      r_initcnt <= '0;
      r_frame   <= '0;
      r_bytecnt <= '0;
      r_resp    <= '1;
      r_len     <= 3'd1;
      r_txcnt   <= '0;
      r_idle    <= 1'b1;
      r_app     <= 1'b0;
      r_busy    <= BW'(ACMD41_BUSY);
      r_stb     <= 1'b0;
      r_idx     <= '0;
      r_arg     <= '0;
      r_crc_ok  <= 1'b0;
    end else begin
      r_sclk_q <= {r_sclk_q[1:0], SCLK};
      r_mosi_q <= {r_mosi_q[0], MOSI};
      r_cs_q   <= {r_cs_q[0], CS};
      r_stb    <= 1'b0;

      if (w_cs) begin
        r_bitcnt <= '0;
      end else if (w_rise) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_rxsh   <= {r_rxsh[5:0], w_mosi};
      end

      if (w_cs) r_wrap <= 1'b0;
      else if (w_byte_done) r_wrap <= 1'b1;
      else if (w_fall) r_wrap <= 1'b0;

      // Wrapped fall loads the next byte; other falls shift in idle-high fill
      if (w_cs || r_state == S_PWRUP) r_tx <= 8'hFF;
      else if (w_fall) r_tx <= r_wrap ? w_tx_next : {r_tx[6:0], 1'b1};

      if (r_state == S_PWRUP) begin
        if (w_cs && w_rise && r_initcnt != IW'(INIT_CLKS)) r_initcnt <= r_initcnt + 1'b1;
        if (r_initcnt >= IW'(INIT_CLKS)) r_state <= S_WAIT;
      end else if (w_cs) begin
        r_state <= S_WAIT;
      end else begin
        case (r_state)
          S_WAIT: if (w_byte_done && w_byte[7:6] == 2'b01) begin
            r_frame   <= {32'h0, w_byte};
            r_bytecnt <= 3'd1;
            r_state   <= S_CMD;
          end
          S_CMD: if (w_byte_done) begin
            if (r_bytecnt == 3'd5) begin
              r_stb    <= 1'b1;
              r_idx    <= w_idx;
              r_arg    <= w_arg;
              r_crc_ok <= w_crc_ok;
              r_idle   <= w_n_idle;
              r_app    <= w_n_app;
              r_busy   <= w_n_busy;
              r_resp   <= w_resp;
              r_len    <= w_len;
              r_txcnt  <= '0;
              r_state  <= S_NCR;
            end else begin
              r_frame   <= {r_frame[31:0], w_byte};
              r_bytecnt <= r_bytecnt + 3'd1;
            end
          end
          S_NCR: if (w_fall && r_wrap) begin
            if (r_txcnt == 4'(NCR - 1)) begin
              r_txcnt <= '0;
              r_state <= S_RESP;
            end else begin
              r_txcnt <= r_txcnt + 4'd1;
            end
          end
          S_RESP: if (w_fall && r_wrap) begin
            if (r_txcnt == {1'b0, r_len}) begin
              r_state <= S_WAIT;
            end else begin
              r_resp  <= {r_resp[31:0], 8'hFF};
              r_txcnt <= r_txcnt + 4'd1;
            end
          end
          default: r_state <= S_WAIT;
        endcase
      end
    end
  end

  assign MISO    = r_tx[7];
  assign CMD_STB = r_stb;
  assign CMD_IDX = r_idx;
  assign CMD_ARG = r_arg;
  assign CRC_OK  = r_crc_ok;
  assign IDLE    = r_idle;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: drives SPI master transactions and compares MISO bytes and
// status outputs against a command-level card model.
module tb_sd_spi_responder;
  localparam int          P_NCR  = 1;
  localparam int          P_BUSY = 2;
  localparam int          P_INIT = 74;
  localparam logic [31:0] P_OCR  = 32'hC0FF8000;

  logic        CLK = 1'b0, RST = 1'b1, SCLK = 1'b0, MOSI = 1'b1, CS = 1'b1;
  logic        MISO, CMD_STB, CRC_OK, IDLE;
  logic [5:0]  CMD_IDX;
  logic [31:0] CMD_ARG;

  sd_spi_responder #(.NCR(P_NCR), .ACMD41_BUSY(P_BUSY), .INIT_CLKS(P_INIT), .OCR(P_OCR)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
    .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG), .CRC_OK(CRC_OK), .IDLE(IDLE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0, stb_cnt = 0;
  always @(negedge CLK) if (CMD_STB === 1'b1) stb_cnt++;

  // Card model
  int          m_clks, m_busy, m_len;
  bit          m_idle, m_app;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;
  logic        m_crc_ok;
  logic [7:0]  m_resp [5];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  task automatic model_reset();
    m_clks = 0; m_busy = P_BUSY; m_idle = 1; m_app = 0;
    m_idx = '0; m_arg = '0; m_crc_ok = 1'b0; m_len = 0;
  endtask

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit good);
    bit was_app;
    m_len = 0;
    if (m_clks < P_INIT) return;
    m_idx = idx; m_arg = arg; m_crc_ok = good; m_len = 1;
    if (!good && (idx == 0 || idx == 8)) begin
      m_resp[0] = 8'h08 + 8'(m_idle);
      return;
    end
    was_app = m_app;
    m_app = 0;
    m_resp[0] = 8'(m_idle);
    if (idx == 0) begin
      m_idle = 1; m_busy = P_BUSY; m_resp[0] = 8'h01;
    end else if (idx == 8) begin
      m_len = 5; m_resp[1] = 0; m_resp[2] = 0;
      m_resp[3] = {4'h0, arg[11:8]}; m_resp[4] = arg[7:0];
    end else if (idx == 55) begin
      m_app = 1;
    end else if (idx == 41 && was_app) begin
      if (m_busy > 0) begin m_busy--; m_resp[0] = 8'h01; end
      else begin m_idle = 0; m_resp[0] = 8'h00; end
    end else if (idx == 58) begin
      m_len = 5;
      for (int k = 0; k < 4; k++) m_resp[k+1] = P_OCR[31-8*k -: 8];
    end else begin
      m_resp[0] = 8'h04 + 8'(m_idle);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 0; i--) begin
      MOSI = tx[i];
      #60 SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      #60 SCLK = 1'b0;
    end
  endtask

  task automatic idle_clks(input int n);
    CS = 1'b1;
    for (int i = 0; i < n; i++) begin
      #60 SCLK = 1'b1;
      #60 SCLK = 1'b0;
    end
    m_clks += n;
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int crc_ovr, input int nextra);
    logic [39:0] f;
    logic [7:0]  cb, rx, expb;
    bit          good, powered;
    int          s0;
    f  = {2'b01, idx, arg};
    cb = {ref_crc7(f), 1'b1};
    if (crc_ovr >= 0) cb = crc_ovr[7:0];
    good    = (cb[7:1] == ref_crc7(f));
    powered = (m_clks >= P_INIT);
    s0      = stb_cnt;
    model_cmd(idx, arg, good);
    CS = 1'b0;
    #60;
    for (int k = 0; k < 6; k++) begin
      spi_byte((k < 5) ? f[39-8*k -: 8] : cb, rx);
      chk("miso_cmd", rx, 8'hFF);
    end
    for (int k = 0; k < nextra; k++) begin
      spi_byte(8'hFF, rx);
      expb = (m_len > 0 && k >= P_NCR && k < P_NCR + m_len) ? m_resp[k-P_NCR] : 8'hFF;
      chk("miso_resp", rx, expb);
    end
    #60 CS = 1'b1;
    #120;
    chk("stb_count", stb_cnt - s0, powered ? 1 : 0);
    chk("cmd_idx", CMD_IDX, m_idx);
    chk("cmd_arg", CMD_ARG, m_arg);
    chk("crc_ok", CRC_OK, m_crc_ok);
    chk("idle", IDLE, m_idle);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    int          s0, ovr;
    model_reset();
    #42;
    chk("rst_miso", MISO, 1'b1);
    chk("rst_idle", IDLE, 1'b1);
    RST = 1'b0;
    #40;
    chk("rst_stb", CMD_STB, 1'b0);
    chk("rst_idx", CMD_IDX, 6'd0);
    chk("rst_arg", CMD_ARG, 32'd0);
    chk("rst_crcok", CRC_OK, 1'b0);

    idle_clks(80);
    do_cmd(6'd0, 32'h0, -1, 2);
    do_cmd(6'd8, 32'h000001AA, -1, 6);
    do_cmd(6'd8, 32'h000001AA, 8'h0F, 2);
    for (int i = 0; i < 3; i++) begin
      do_cmd(6'd55, 32'h0, -1, 2);
      do_cmd(6'd41, 32'h40000000, 8'hFF, 2);
    end
    do_cmd(6'd58, 32'h0, -1, 6);

    // Aborted frame: CS rises after three bytes
    s0 = stb_cnt;
    CS = 1'b0;
    #60;
    spi_byte(8'h40, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    #60 CS = 1'b1;
    #120;
    chk("abort_stb", stb_cnt - s0, 0);
    do_cmd(6'd0, 32'h0, -1, 2);
    do_cmd(6'd17, 32'h00001000, -1, 2);
    do_cmd(6'd41, 32'h0, -1, 2);

    for (int r = 0; r < 14; r++) begin
      case ($urandom_range(0, 6))
        0: ridx = 6'd0;
        1: ridx = 6'd8;
        2, 3: ridx = 6'd55;
        4: ridx = 6'd41;
        5: ridx = 6'd58;
        default: ridx = 6'($urandom_range(0, 63));
      endcase
      rarg = $urandom;
      ovr  = -1;
      if ($urandom_range(0, 4) == 0) ovr = int'({ref_crc7({2'b01, ridx, rarg}), 1'b1} ^ 8'h02);
      do_cmd(ridx, rarg, ovr, P_NCR + 5 + $urandom_range(0, 1));
    end

    // Reset in the middle of an R7 response
    do_cmd(6'd0, 32'h0, -1, 2);
    model_cmd(6'd8, 32'h000002AA, 1'b1);
    CS = 1'b0;
    #60;
    spi_byte(8'h48, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx);
    spi_byte(8'h02, rx); spi_byte(8'hAA, rx);
    spi_byte({ref_crc7({2'b01, 6'd8, 32'h000002AA}), 1'b1}, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'hFF, rx);
    chk("r7_byte0", rx, m_resp[0]);
    spi_byte(8'hFF, rx);
    chk("r7_byte1", rx, m_resp[1]);
    #60;
    chk("pre_rst_miso", MISO, m_resp[2][7]);
    RST = 1'b1;
    #30;
    chk("midrst_miso", MISO, 1'b1);
    chk("midrst_idle", IDLE, 1'b1);
    chk("midrst_stb", CMD_STB, 1'b0);
    CS = 1'b1;
    #40 RST = 1'b0;
    model_reset();
    #40;
    chk("midrst_idx", CMD_IDX, 6'd0);
    chk("midrst_arg", CMD_ARG, 32'd0);
    idle_clks(40);
    do_cmd(6'd0, 32'h0, -1, 3);
    idle_clks(40);
    do_cmd(6'd0, 32'h0, -1, 3);
    do_cmd(6'd8, 32'h00000155, -1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
